alu_result_buf: RTL and testbench
=================================

Name: alu_result_buf

Overview:
- Execute-stage output buffer sitting directly downstream of the 16-bit ALU.
- Captures the ALU result (Out, Ofl, Z, resultSign) together with destination-register tag and write enable.
- Hands the result to the memory/writeback stage through a valid/ready handshake.
- Holds a 2-entry skid buffer so a back-pressured downstream does not drop results; maintains committed condition codes for branch resolution.

Parameters:
- WIDTH, 16, datapath width of ALU result
- TAG_W, 3, destination register tag width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-low reset; sampled on rising clk, 0 = reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  ALU result present
- in_ready  out  1  buffer can accept this cycle
- alu_out  in  WIDTH  ALU Out
- alu_ofl  in  1  ALU Ofl
- alu_z  in  1  ALU Z
- alu_sign  in  1  ALU resultSign
- in_tag  in  TAG_W  destination register
- in_wr  in  1  register write enable
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_data  out  WIDTH  head result
- out_tag  out  TAG_W  head tag
- out_wr  out  1  head write enable
- cc_z, cc_n, cc_v  out  1 each  committed zero/negative/overflow flags
- ofl_count  out  16  overflow commit counter (see Optional Feature)

Behaviour:
- State register: EMPTY, ONE (main full), TWO (main and skid full).
- in_ready = (state != TWO), decoded from registered state only, no combinational path from out_ready. out_valid = (state != EMPTY).
- out_* driven from main entry only.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: accepted in cycle N, presented on out_* in cycle N+1.
- EMPTY: accept -> ONE, main <= input.
- ONE, accept & drain: stay ONE, main <= input.
- ONE, accept only: -> TWO, skid <= input.
- ONE, drain only: -> EMPTY.
- TWO, drain: -> ONE, main <= skid. No accept is possible in TWO.
- Order strictly FIFO. Entries with in_wr=0 are still buffered and passed through.
- cc_z/cc_n/cc_v <= main alu_z/alu_sign/alu_ofl on drain only; unchanged otherwise.
- flush (rst high): state <= EMPTY next cycle, both entries discarded, that cycle's input not accepted, drain that cycle still updates cc.
- rst low: state EMPTY, out_valid 0, in_ready 1 after reset edge, out_data/out_tag/out_wr 0, cc_* 0, ofl_count 0.
- rst takes priority over flush; reset mid-transfer drops entries with no drain credit.
- X on in_* while in_valid=0 must not propagate to outputs.

Optional Feature:
- Macro ALU_OFL_COUNT_EN.
- Defined: ofl_count increments by 1 on each drain whose entry has ofl=1; saturates at 16'hFFFF; cleared by rst only, not by flush.
- Undefined: ofl_count tied to 0, no counter flops.

Test Plan:
- Reset, then in_valid=1 with alu_out=16'h0007, tag=3, out_ready=1 -> next cycle out_valid=1, out_data=7, out_tag=3; following cycle cc_z=0, cc_n=0.
- out_ready=0, push 16'h0001 then 16'hFFFB -> in_ready=0 after second push; release out_ready -> 1 then FFFB drained in order; cc_n=1 after second drain.
- Continuous in_valid & out_ready for 100 random results -> one output per cycle, in_ready never drops, values match inputs delayed 1 cycle.
- Buffer in TWO, assert flush for 1 cycle -> out_valid=0 next cycle, in_ready=1, no stale data emitted, cc unchanged unless drain coincided.
- Drain results with alu_z=1, then alu_ofl=1 -> cc_z=1 then cc_v=1; with ALU_OFL_COUNT_EN defined, 3 overflow drains -> ofl_count=3; without it, ofl_count=0.
- Drive rst=0 while in TWO -> next cycle out_valid=0, cc_*=0, in_ready=1 after rst=1.

Source files
------------

// File: rtl/alu_result_buf.sv
// Execute-stage result buffer: 2-entry skid FIFO between the ALU and memory/writeback,
// plus committed condition codes. Define ALU_OFL_COUNT_EN to build the overflow commit counter.
module alu_result_buf #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ofl,
  input  logic             alu_z,
  input  logic             alu_sign,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_wr,
  output logic             cc_z,
  output logic             cc_n,
  output logic             cc_v,
  output logic [15:0]      ofl_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             ofl;
    logic             z;
    logic             sign;
    logic [TAG_W-1:0] tag;
    logic             wr;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, in_e;
  logic   cc_z_q, cc_n_q, cc_v_q;
  logic   accept, drain;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready;

  assign in_e = '{data: alu_out, ofl: alu_ofl, z: alu_z, sign: alu_sign,
                  tag: in_tag, wr: in_wr};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        main_d  = in_e;
      end
      ONE: begin
        if (accept && drain) begin
          main_d = in_e;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = in_e;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: if (drain) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // Clearing the payload on flush keeps stale results off out_* entirely.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cc_z_q  <= 1'b0;
      cc_n_q  <= 1'b0;
      cc_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      if (drain) begin
        cc_z_q <= main_q.z;
        cc_n_q <= main_q.sign;
        cc_v_q <= main_q.ofl;
      end
    end
  end

  assign out_data = main_q.data;
  assign out_tag  = main_q.tag;
  assign out_wr   = main_q.wr;
  assign cc_z     = cc_z_q;
  assign cc_n     = cc_n_q;
  assign cc_v     = cc_v_q;

`ifdef ALU_OFL_COUNT_EN
  logic [15:0] ofl_cnt_q;
  // Saturating; survives flush so software sees every committed overflow.
  always_ff @(posedge clk) begin
    if (!rst)
      ofl_cnt_q <= '0;
    else if (drain && main_q.ofl && ofl_cnt_q != 16'hFFFF)
      ofl_cnt_q <= ofl_cnt_q + 16'd1;
  end
  assign ofl_count = ofl_cnt_q;
`else
  assign ofl_count = '0;
`endif

endmodule

// File: tb/tb_alu_result_buf.sv
// Directed bench for alu_result_buf: queue-based reference model checked every cycle,
// plus hand-computed literal checks along the directed sequence.
module tb_alu_result_buf;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, alu_ofl, alu_z, alu_sign, in_wr;
  logic        out_valid, out_ready, out_wr, cc_z, cc_n, cc_v;
  logic [15:0] alu_out, out_data, ofl_count;
  logic [2:0]  in_tag, out_tag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_result_buf #(.WIDTH(16), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_z(alu_z), .alu_sign(alu_sign),
    .in_tag(in_tag), .in_wr(in_wr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_wr(out_wr),
    .cc_z(cc_z), .cc_n(cc_n), .cc_v(cc_v), .ofl_count(ofl_count)
  );

  typedef struct {
    logic [15:0] d;
    logic        o, z, s;
    logic [2:0]  t;
    logic        w;
  } ent_t;

  ent_t q[$];
  logic m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;
  int   m_cnt = 0;
  bit   en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of at most two results.
  always @(posedge clk) begin
    bit dr, ac;
    if (!rst) begin
      q.delete();
      m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_cnt = 0;
      en = 1'b1;
    end else begin
      dr = (q.size() > 0) && out_ready;
      ac = in_valid && (q.size() < 2) && !flush;
      if (dr) begin
        m_z = q[0].z; m_n = q[0].s; m_v = q[0].o;
`ifdef ALU_OFL_COUNT_EN
        if (q[0].o && m_cnt < 65535) m_cnt++;
`endif
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (ac) q.push_back('{alu_out, alu_ofl, alu_z, alu_sign, in_tag, in_wr});
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("m_cc", {29'd0, cc_z, cc_n, cc_v}, {29'd0, m_z, m_n, m_v});
      chk("m_ofl_count", {16'd0, ofl_count}, m_cnt);
      if (q.size() > 0)
        chk("m_head", {12'd0, out_data, out_tag, out_wr}, {12'd0, q[0].d, q[0].t, q[0].w});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic o, input logic [2:0] t, input logic w);
    in_valid = 1'b1; alu_out = d; alu_ofl = o; alu_z = (d == 16'd0);
    alu_sign = d[15]; in_tag = t; in_wr = w;
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0; alu_out = 'x; alu_ofl = 'x; alu_z = 'x; alu_sign = 'x;
    in_tag = 'x; in_wr = 'x;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle();
    cyc(); cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_fields", {12'd0, out_data, out_tag, out_wr}, 32'd0);
    chk("rst_cc", {29'd0, cc_z, cc_n, cc_v}, 32'd0);
    chk("rst_ofl_count", {16'd0, ofl_count}, 32'd0);
    rst = 1'b1;
    cyc();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single result, one-cycle latency.
    out_ready = 1'b1;
    drive(16'h0007, 1'b0, 3'd3, 1'b1);
    idle();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data", {16'd0, out_data}, 32'h7);
    chk("t1_tag", {29'd0, out_tag}, 32'd3);
    cyc();
    chk("t1_cc_zn", {30'd0, cc_z, cc_n}, 32'd0);

    // Back-pressure fills skid; drain preserves order.
    out_ready = 1'b0;
    drive(16'h0001, 1'b0, 3'd1, 1'b0);
    drive(16'hFFFB, 1'b0, 3'd2, 1'b1);
    idle();
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    chk("t2_first", {16'd0, out_data}, 32'h0001);
    cyc();
    chk("t2_second", {16'd0, out_data}, 32'hFFFB);
    cyc();
    chk("t2_cc_n", {31'd0, cc_n}, 32'd1);
    chk("t2_empty", {31'd0, out_valid}, 32'd0);

    // Streaming: one in, one out every cycle.
    for (int i = 0; i < 100; i++) begin
      drive(16'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
      chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
    end
    idle();
    cyc();

    // Flush while full, no coincident drain: cc untouched.
    out_ready = 1'b0;
    drive(16'h8000, 1'b0, 3'd4, 1'b1);
    drive(16'h1234, 1'b0, 3'd5, 1'b1);
    idle();
    flush = 1'b1;
    drive(16'h5555, 1'b0, 3'd6, 1'b1);
    idle();
    flush = 1'b0;
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("t4_still_empty", {31'd0, out_valid}, 32'd0);

    // Flush coinciding with a drain of a zero result: cc_z commits.
    drive(16'h0000, 1'b0, 3'd7, 1'b1);
    idle();
    out_ready = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t4_flush_drain_cc_z", {31'd0, cc_z}, 32'd1);
    chk("t4_flush_drain_valid", {31'd0, out_valid}, 32'd0);

    // Reset while in TWO.
    out_ready = 1'b0;
    drive(16'hF00F, 1'b1, 3'd1, 1'b1);
    drive(16'h0F0F, 1'b1, 3'd2, 1'b1);
    idle();
    rst = 1'b0;
    cyc();
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_cc", {29'd0, cc_z, cc_n, cc_v}, 32'd0);
    rst = 1'b1;
    cyc();
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);

    // Overflow commits.
    out_ready = 1'b1;
    drive(16'h7FFF, 1'b1, 3'd1, 1'b1);
    drive(16'h8001, 1'b1, 3'd2, 1'b1);
    drive(16'h0003, 1'b1, 3'd3, 1'b0);
    idle();
    cyc();
    chk("t5_cc_v", {31'd0, cc_v}, 32'd1);
`ifdef ALU_OFL_COUNT_EN
    chk("t5_ofl_count", {16'd0, ofl_count}, 32'd3);
`else
    chk("t5_ofl_count", {16'd0, ofl_count}, 32'd0);
`endif
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
